// File: rtl/pc_pkg.sv
// pc_pkg: redirect mode encoding and default widths shared by the PC generator
package pc_pkg;
    typedef enum logic [1:0] {
        MODE_BRANCH = 2'd0,
        MODE_JUMP   = 2'd1,
        MODE_JREG   = 2'd2,
        MODE_RET    = 2'd3
    } redir_mode_e;
    localparam int PC_W_DEF      = 32;
    localparam int IMM_W_DEF     = 16;
    localparam int JADDR_W_DEF   = 26;
    localparam int INC_DEF       = 1;
    localparam int RAS_DEPTH_DEF = 4;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect bus from branch resolution and fetch PC/RAS status back out
interface pc_gen_if import pc_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int JADDR_W = JADDR_W_DEF
);
    logic               stall;
    logic               redir_valid;
    logic [1:0]         redir_mode;
    logic [PC_W-1:0]    redir_pc;
    logic [IMM_W-1:0]   redir_imm;
    logic [JADDR_W-1:0] redir_jaddr;
    logic [PC_W-1:0]    redir_reg;
    logic               redir_link;
    logic [PC_W-1:0]    pc;
    logic               ras_empty;
    logic               ras_full;
    logic               ras_miss;
    modport master (
        output stall, redir_valid, redir_mode, redir_pc, redir_imm, redir_jaddr, redir_reg, redir_link,
        input  pc, ras_empty, ras_full, ras_miss
    );
    modport slave (
        input  stall, redir_valid, redir_mode, redir_pc, redir_imm, redir_jaddr, redir_reg, redir_link,
        output pc, ras_empty, ras_full, ras_miss
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; push+pop together replaces the top entry
module pc_ras import pc_pkg::*; #(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CNT_W'(DEPTH);
    assign top   = mem_q[top_q];
    // pop is only asserted by the caller when the stack is non-empty
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (push && pop) begin
            mem_d[top_q] = wdata;
        end else if (push) begin
            top_d        = top_q + 1'b1;
            mem_d[top_d] = wdata;
            cnt_d        = full ? cnt_q : cnt_q + 1'b1;
        end else if (pop) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered fetch PC with branch/jump/jreg/return redirects and a return stack
module pc_gen import pc_pkg::*; #(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              IMM_W     = IMM_W_DEF,
    parameter int              JADDR_W   = JADDR_W_DEF,
    parameter int              INC       = INC_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);
    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
    logic [PC_W-1:0] pc_q, pc_d, link, branch_tgt, jump_tgt, ret_tgt, target, ras_top;
    logic            ras_miss_q, ras_miss_d, ras_push, ras_pop, ras_empty, is_ret;
    always_comb begin
        link       = bus.redir_pc + INC_V;
        branch_tgt = link + {{(PC_W-IMM_W){bus.redir_imm[IMM_W-1]}}, bus.redir_imm};
        jump_tgt   = {link[PC_W-1:JADDR_W], bus.redir_jaddr};
        ret_tgt    = ras_empty ? bus.redir_reg : ras_top;
        target     = bus.redir_mode == MODE_BRANCH ? branch_tgt :
                     bus.redir_mode == MODE_JUMP   ? jump_tgt   :
                     bus.redir_mode == MODE_JREG   ? bus.redir_reg : ret_tgt;
        is_ret     = bus.redir_valid && bus.redir_mode == MODE_RET;
        ras_pop    = is_ret && !ras_empty;
        ras_push   = bus.redir_valid && bus.redir_link;
        ras_miss_d = is_ret && ras_empty;
        pc_d       = bus.redir_valid ? target : bus.stall ? pc_q : pc_q + INC_V;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ras_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ras_miss_q <= ras_miss_d;
        end
    end
    pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (link),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (bus.ras_full)
    );
    assign bus.pc        = pc_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_miss  = ras_miss_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench comparing pc_gen against a queue-based PC/RAS model
module tb_pc_gen;
    import pc_pkg::*;
    typedef struct packed {
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        m;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    exp_t        sb[$];
    logic [31:0] ras_m[$];
    logic [31:0] m_pc = '0;
    logic        m_miss = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ret_exp [5] = '{32'h241, 32'h231, 32'h221, 32'h211, 32'hAAAA};
    pc_gen_if #(.PC_W(32), .IMM_W(16), .JADDR_W(26)) bus();
    pc_gen #(.PC_W(32), .IMM_W(16), .JADDR_W(26), .INC(1), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rn, input logic st, input logic rv, input logic [1:0] md,
                        input logic [31:0] rpc, input logic [15:0] imm, input logic [25:0] ja,
                        input logic [31:0] rr, input logic lk);
        logic [31:0] lnk;
        exp_t        o;
        rst_n           = rn;
        bus.stall       = st;
        bus.redir_valid = rv;
        bus.redir_mode  = md;
        bus.redir_pc    = rpc;
        bus.redir_imm   = imm;
        bus.redir_jaddr = ja;
        bus.redir_reg   = rr;
        bus.redir_link  = lk;
        lnk = rpc + 32'd1;
        if (!rn) begin
            m_pc = '0;
            ras_m.delete();
            m_miss = 1'b0;
        end else if (rv) begin
            m_miss = (md == MODE_RET) && (ras_m.size() == 0);
            if (md == MODE_BRANCH) m_pc = lnk + 32'($signed(imm));
            else if (md == MODE_JUMP) m_pc = {lnk[31:26], ja};
            else if (md == MODE_JREG) m_pc = rr;
            else m_pc = m_miss ? rr : ras_m.pop_back();
            if (lk) begin
                ras_m.push_back(lnk);
                if (ras_m.size() > 4) void'(ras_m.pop_front());
            end
        end else begin
            m_miss = 1'b0;
            if (!st) m_pc = m_pc + 32'd1;
        end
        sb.push_back('{m_pc, ras_m.size() == 0, ras_m.size() == 4, m_miss});
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("pc", bus.pc, o.pc);
        check("ras_empty", 32'(bus.ras_empty), 32'(o.e));
        check("ras_full", 32'(bus.ras_full), 32'(o.f));
        check("ras_miss", 32'(bus.ras_miss), 32'(o.m));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step(0, 0, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        step(0, 0, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_empty", 32'(bus.ras_empty), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        check("seq4", bus.pc, 32'd4);
        step(1, 0, 1, MODE_BRANCH, 32'h10, 16'hFFFE, 0, 0, 0);
        check("br_neg", bus.pc, 32'h0F);
        step(1, 0, 1, MODE_BRANCH, 32'h10, 16'h0005, 0, 0, 0);
        check("br_pos", bus.pc, 32'h16);
        step(1, 0, 1, MODE_JUMP, 32'h0FFFFFFF, 0, 26'h0000123, 0, 0);
        check("jump_hi", bus.pc, 32'h10000123);
        for (int i = 1; i <= 3; i++) step(1, 0, 1, MODE_JUMP, 32'h20 * i, 0, 26'h100, 0, 1);
        step(1, 0, 1, MODE_RET, 32'h150, 0, 0, 32'hDEAD, 0);
        check("ret1", bus.pc, 32'h61);
        step(1, 0, 1, MODE_RET, 32'h150, 0, 0, 32'hDEAD, 0);
        check("ret2", bus.pc, 32'h41);
        step(1, 0, 1, MODE_RET, 32'h150, 0, 0, 32'hDEAD, 0);
        check("ret3", bus.pc, 32'h21);
        check("ret_empty", 32'(bus.ras_empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, MODE_JUMP, 32'h200 + 32'(16 * i), 0, 26'h80, 0, 1);
            if (i == 3) check("full4", 32'(bus.ras_full), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, MODE_RET, 32'h90, 0, 0, 32'hAAAA, 0);
            check("ovf_ret", bus.pc, ret_exp[i]);
        end
        check("miss_pulse", 32'(bus.ras_miss), 32'd1);
        step(1, 0, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        step(1, 0, 1, MODE_JUMP, 32'h500, 0, 26'h40, 0, 1);
        step(1, 0, 1, MODE_RET, 32'h600, 0, 0, 32'hCCCC, 1);
        check("retcall", bus.pc, 32'h501);
        step(1, 0, 1, MODE_RET, 32'h30, 0, 0, 32'hCCCC, 0);
        check("retcall_pop", bus.pc, 32'h601);
        step(1, 0, 1, MODE_RET, 32'h700, 0, 0, 32'hBBBB, 1);
        check("retcall_empty", bus.pc, 32'hBBBB);
        step(1, 0, 1, MODE_RET, 32'h30, 0, 0, 32'h0, 0);
        check("retcall_empty_pop", bus.pc, 32'h701);
        step(1, 1, 1, MODE_JREG, 32'h30, 0, 0, 32'h300, 0);
        check("stall_flush", bus.pc, 32'h300);
        step(1, 1, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        step(1, 1, 0, MODE_BRANCH, 0, 0, 0, 0, 0);
        check("stall_hold", bus.pc, 32'h300);
        step(1, 0, 1, MODE_BRANCH, 32'h300, 16'h0004, 0, 0, 0);
        step(1, 0, 1, MODE_JREG, 32'h301, 0, 0, 32'h123, 1);
        check("b2b", bus.pc, 32'h123);
        step(0, 0, 1, MODE_JUMP, 32'h40, 0, 26'h3, 0, 1);
        check("midrst_pc", bus.pc, 32'h0);
        check("midrst_empty", 32'(bus.ras_empty), 32'd1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 29) != 0, 1'($urandom), $urandom_range(0, 2) == 0, 2'($urandom),
                 $urandom, 16'($urandom), 26'($urandom), $urandom, 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-PC generator for the word-addressed MIPS core; replaces the combinational branch-target adder with a registered PC plus redirect logic.
- Owns the fetch PC register and computes the sequential, branch, jump, jump-register and return targets.
- Includes a small circular return-address stack (RAS) for call/return redirects.
- Sits between the branch-resolution stage (source of redirects) and instruction memory (consumer of pc).

Parameters:
- PC_W, 32: PC width in bits (word address).
- IMM_W, 16: branch immediate width; sign-extended to PC_W.
- JADDR_W, 26: absolute jump field width; must be less than PC_W.
- INC, 1: sequential increment in PC units (1 = word addressing).
- RESET_PC, 0: PC value after reset.
- RAS_DEPTH, 4: return stack entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold pc; ignored when redir_valid=1
- redir_valid  in  1  redirect request this cycle
- redir_mode  in  2  0 BRANCH, 1 JUMP, 2 JREG, 3 RET
- redir_pc  in  PC_W  PC of the redirecting instruction
- redir_imm  in  IMM_W  branch offset (BRANCH)
- redir_jaddr  in  JADDR_W  jump field (JUMP)
- redir_reg  in  PC_W  register target (JREG; RET fallback)
- redir_link  in  1  push redir_pc+INC onto the RAS (call)
- pc  out  PC_W  current fetch PC (registered)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_miss  out  1  one-cycle pulse: RET issued with an empty RAS

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC; RAS count=0 and top pointer=0.
  - ras_empty=1, ras_full=0, ras_miss=0.
  - Reset overrides every other input.
- Next-PC priority, applied at each clock edge: reset > redirect > stall > sequential.
  - Sequential: pc <= pc+INC.
  - Stall without redirect: pc holds.
- Redirect targets. Latency is 1: pc equals the target on the cycle after redir_valid. All sums wrap modulo 2^PC_W.
  - BRANCH: redir_pc + INC + sext(redir_imm).
  - JUMP: {(redir_pc+INC)[PC_W-1:JADDR_W], redir_jaddr}.
  - JREG: redir_reg.
  - RET: the RAS top entry if count>0. If the RAS is empty: redir_reg, ras_miss=1 for one cycle, and no pop.
- RAS is updated only when redir_valid=1:
  - Push (redir_link=1): write redir_pc+INC at top+1; top advances modulo RAS_DEPTH.
  - Count saturates at RAS_DEPTH. A push when full overwrites the oldest entry; there is no error flag.
  - Pop (mode=RET, count>0): top retreats; count decrements.
  - RET with redir_link=1 (return-and-call): the pop target is used for pc, then the new link replaces the top entry. Count is unchanged; if the RAS was empty, count becomes 1.
  - redir_link is ignored when redir_valid=0.
- ras_empty and ras_full are registered and reflect the count after the edge.
- A redirect while stall=1 takes effect (flush beats stall).
- Consecutive redirects on back-to-back cycles are all honoured; each one uses its own redir_pc.

Decomposition:
- Shared package pc_pkg holds the redirect mode constants (MODE_BRANCH=0, MODE_JUMP=1, MODE_JREG=2, MODE_RET=3) and the default width constants.
- One sub-module, pc_ras: circular return stack with push/pop/replace, count, empty/full and a top-entry read port.
- Target arithmetic stays inline in pc_gen.

Test Plan:
- Reset then run 4 cycles with no stall (RESET_PC=0) -> pc sequence 0,1,2,3,4; ras_empty=1.
- BRANCH, redir_pc=0x10, imm=0xFFFE -> next pc=0x0F. Same with imm=0x0005 -> pc=0x16.
- JUMP, redir_pc=0x0FFFFFFF, jaddr=0x0000123 -> pc=0x10000123, because the upper bits come from redir_pc+INC.
- Three calls (JUMP with link) at redir_pc=0x20, 0x40, 0x60, then three RETs -> pc=0x61, 0x41, 0x21; ras_empty=1 after the last pop.
- RAS_DEPTH=4 with 5 pushes, then 5 RETs with redir_reg=0xAAAA -> first 4 RETs pop the newest 4 links; the fifth gives pc=0xAAAA with a ras_miss pulse; ras_full=1 after the 4th push.
- stall=1 together with a JREG redirect to 0x300 -> pc=0x300 next cycle. Continued stall without redirect holds 0x300. rst_n=0 mid-sequence -> pc=RESET_PC and ras_empty=1 on the next edge.
